// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: drains NUM_CH source FIFOs into one sink FIFO using
// round-robin arbitration. It also programs the almost-empty and almost-full
// thresholds of every FIFO through a small control FSM.
module fifo_rr_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int WORD_SIZE = 10,
  parameter int PTR_SIZE  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init,
  input  logic [PTR_SIZE-1:0]         umbral_ae_in,
  input  logic [PTR_SIZE-1:0]         umbral_af_in,
  input  logic [NUM_CH-1:0]           fifo_empty,
  input  logic [NUM_CH-1:0]           fifo_error,
  input  logic [NUM_CH*WORD_SIZE-1:0] fifo_data,
  input  logic                        out_almost_full,
  input  logic                        out_full,
  output logic [NUM_CH-1:0]           fifo_rd,
  output logic                        out_push,
  output logic [WORD_SIZE-1:0]        out_data,
  output logic [PTR_SIZE-1:0]         cfg_ae,
  output logic [PTR_SIZE-1:0]         cfg_af,
  output logic                        cfg_load,
  output logic [2:0]                  state,
  output logic                        idle_out,
  output logic                        error_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam logic [PTR_SIZE-1:0] AE_DEFAULT = PTR_SIZE'(2);
  localparam logic [PTR_SIZE-1:0] AF_DEFAULT = PTR_SIZE'(6);

  logic [2:0]      state_q, state_nx;
  logic [CH_W-1:0] last_grant;
  logic            push_pending;   // a pop was granted last cycle
  logic [CH_W-1:0] push_idx;       // channel that pop came from
  logic [NUM_CH-1:0] eligible;
  logic            grant_valid;
  logic [CH_W-1:0] grant_idx;
  int              rr_idx;

  assign state     = state_q;
  assign cfg_load  = (state_q == ST_INIT);
  assign idle_out  = (state_q == ST_IDLE);
  assign error_out = (state_q == ST_ERROR);
  assign out_push  = push_pending;

  // Word returns one cycle after the pop, so it is taken from the registered channel.
  assign out_data = push_pending ? fifo_data[push_idx*WORD_SIZE +: WORD_SIZE] : '0;

  // Per-channel eligibility. The channel popped last cycle is masked because its
  // empty flag has not caught up with that pop yet. Grants pause while a
  // reload is requested so the in-flight push can drain.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = (state_q == ST_ACTIVE) && !init && !fifo_empty[i] &&
                    !out_almost_full && !(push_pending && (push_idx == CH_W'(i)));
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    // NOTE: every variable gets a default before any branch; otherwise paths that skip an assignment would infer latches.
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    rr_idx      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_idx = (int'(last_grant) + k) % NUM_CH;
      if (!grant_valid && eligible[CH_W'(rr_idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(rr_idx);
      end
    end
    fifo_rd = grant_valid ? (NUM_CH'(1) << grant_idx) : '0;
  end

  // Next-state logic. Error conditions override everything except RESET.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_RESET:  state_nx = ST_INIT;
      ST_INIT:   if (!init) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (init)                  state_nx = ST_INIT;
        else if (!(&fifo_empty))   state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init) begin
          if (!push_pending)       state_nx = ST_INIT;
        end else if ((&fifo_empty) && !push_pending) begin
          state_nx = ST_IDLE;
        end
      end
      ST_ERROR:  state_nx = ST_ERROR;
      default:   state_nx = ST_ERROR;
    endcase
    if ((state_q != ST_RESET) && ((|fifo_error) || (out_full && push_pending)))
      state_nx = ST_ERROR;
  end

  // State, threshold and arbitration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RESET;
      cfg_ae       <= AE_DEFAULT;
      cfg_af       <= AF_DEFAULT;
      last_grant   <= CH_W'(NUM_CH - 1);
      push_pending <= 1'b0;
      push_idx     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q      <= state_nx;
      if (state_q == ST_INIT) begin
        cfg_ae <= umbral_ae_in;
        cfg_af <= umbral_af_in;
      end
      push_pending <= grant_valid;
      if (grant_valid) begin
        last_grant <= grant_idx;
        push_idx   <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler. Inputs change on the falling edge.
// Outputs are sampled 1 time unit later, well before the next rising edge.
module tb_fifo_rr_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [2:0]  umbral_ae_in, umbral_af_in;
  logic [3:0]  fifo_empty, fifo_error;
  logic [39:0] fifo_data;
  logic        out_almost_full, out_full;
  logic [3:0]  fifo_rd;
  logic        out_push;
  logic [9:0]  out_data;
  logic [2:0]  cfg_ae, cfg_af;
  logic        cfg_load;
  logic [2:0]  state;
  logic        idle_out, error_out;

  int checks = 0;
  int errors = 0;
  logic [9:0] dv [4];

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.NUM_CH(4), .WORD_SIZE(10), .PTR_SIZE(3)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_ae_in(umbral_ae_in), .umbral_af_in(umbral_af_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error), .fifo_data(fifo_data),
    .out_almost_full(out_almost_full), .out_full(out_full),
    .fifo_rd(fifo_rd), .out_push(out_push), .out_data(out_data),
    .cfg_ae(cfg_ae), .cfg_af(cfg_af), .cfg_load(cfg_load), .state(state),
    .idle_out(idle_out), .error_out(error_out)
  );

  // Compares {fifo_rd, out_push, out_data} against hand-derived values.
  // The comparison is written out at each call site.
  task automatic test_reset();
    #2;
    checks++;
    if ({state, fifo_rd, out_push, out_data} !== {3'd0, 4'b0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL reset_outputs state=%0d rd=%b push=%b data=%h expected 0/0000/0/000",
               state, fifo_rd, out_push, out_data);
    end
    checks++;
    if ({cfg_ae, cfg_af, cfg_load, idle_out, error_out} !== {3'd2, 3'd6, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_cfg ae=%0d af=%0d load=%b idle=%b err=%b expected 2/6/0/0/0",
               cfg_ae, cfg_af, cfg_load, idle_out, error_out);
    end
  endtask

  task automatic test_init();
    int loads = 0;
    @(negedge clk); reset = 1'b0; init = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) init = 1'b0;
      #1;
      if (cfg_load) loads++;
      checks++;
      if (state !== 3'd1) begin
        errors++;
        $display("FAIL init_state cycle=%0d state=%0d expected 1", k, state);
      end
    end
    @(negedge clk); #1;
    if (cfg_load) loads++;
    checks++;
    if (loads !== 3) begin
      errors++;
      $display("FAIL init_load_cycles got=%0d expected 3", loads);
    end
    checks++;
    if ({state, idle_out, cfg_ae, cfg_af} !== {3'd2, 1'b1, 3'd1, 3'd5}) begin
      errors++;
      $display("FAIL init_done state=%0d idle=%b ae=%0d af=%0d expected 2/1/1/5",
               state, idle_out, cfg_ae, cfg_af);
    end
  endtask

  // Empty flags drop, then grants rotate 0,1,2,3,0 with pushes trailing one cycle.
  task automatic test_round_robin();
    logic [3:0] exp_rd;
    @(negedge clk); fifo_empty = 4'b0000; #1;
    checks++;
    if ({fifo_rd, idle_out} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL rr_idle_nogrant rd=%b idle=%b expected 0000/1", fifo_rd, idle_out);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      exp_rd = 4'b0001 << (k % 4);
      checks++;
      if ({fifo_rd, out_push} !== {exp_rd, (k > 0)} ||
          (k > 0 && out_data !== dv[(k - 1) % 4])) begin
        errors++;
        $display("FAIL rr_seq cycle=%0d rd=%b push=%b data=%h expected %b/%b/%h",
                 k, fifo_rd, out_push, out_data, exp_rd, (k > 0), dv[(k + 3) % 4]);
      end
    end
    @(negedge clk); fifo_empty = 4'b1111; #1;
    checks++;
    if ({fifo_rd, out_push, out_data} !== {4'b0000, 1'b1, dv[0]}) begin
      errors++;
      $display("FAIL rr_drain rd=%b push=%b data=%h expected 0000/1/%h",
               fifo_rd, out_push, out_data, dv[0]);
    end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({state, out_push} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL rr_back_idle state=%0d push=%b expected 2/0", state, out_push);
    end
  endtask

  // Only channel 2 has data: it can pop every other cycle at most.
  task automatic test_single_channel();
    @(negedge clk); fifo_empty = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({fifo_rd, out_push} !== {((k % 2 == 0) ? 4'b0100 : 4'b0000), (k % 2 == 1)} ||
          (k % 2 == 1 && out_data !== dv[2])) begin
        errors++;
        $display("FAIL single_ch cycle=%0d rd=%b push=%b data=%h", k, fifo_rd, out_push, out_data);
      end
    end
    @(negedge clk); fifo_empty = 4'b1111;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL single_back_idle state=%0d expected 2", state);
    end
  endtask

  // Sink almost-full stalls grants at once; the one in-flight push still lands.
  task automatic test_almost_full();
    logic [14:0] exp [7];
    exp[0] = {4'b1000, 1'b0, 10'd0};
    exp[1] = {4'b0001, 1'b1, dv[3]};
    exp[2] = {4'b0000, 1'b1, dv[0]};
    exp[3] = {4'b0000, 1'b0, 10'd0};
    exp[4] = {4'b0000, 1'b0, 10'd0};
    exp[5] = {4'b0010, 1'b0, 10'd0};
    exp[6] = {4'b0100, 1'b1, dv[1]};
    @(negedge clk); fifo_empty = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 2) out_almost_full = 1'b1;
      if (k == 5) out_almost_full = 1'b0;
      #1;
      checks++;
      if ({fifo_rd, out_push, out_data} !== exp[k]) begin
        errors++;
        $display("FAIL almost_full cycle=%0d got rd=%b push=%b data=%h expected %b/%b/%h",
                 k, fifo_rd, out_push, out_data, exp[k][14:11], exp[k][10], exp[k][9:0]);
      end
    end
    @(negedge clk); fifo_empty = 4'b1111;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL af_back_idle state=%0d expected 2", state);
    end
  endtask

  // A source error latches ERROR until reset and blocks all grants.
  task automatic test_error();
    @(negedge clk); fifo_empty = 4'b0000;
    @(negedge clk); #1;
    checks++;
    if (fifo_rd !== 4'b1000) begin
      errors++;
      $display("FAIL err_pre_grant rd=%b expected 1000", fifo_rd);
    end
    @(negedge clk); fifo_error = 4'b0010;
    @(negedge clk); fifo_error = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({state, error_out, fifo_rd} !== {3'd4, 1'b1, 4'b0000}) begin
        errors++;
        $display("FAIL err_sticky cycle=%0d state=%0d err=%b rd=%b expected 4/1/0000",
                 k, state, error_out, fifo_rd);
      end
    end
  endtask

  // Reset with a push pending clears everything without a clock edge.
  // Afterwards a push into a full sink must trip ERROR.
  task automatic test_async_reset_and_full();
    @(negedge clk); reset = 1'b1; fifo_empty = 4'b1111;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); @(negedge clk); fifo_empty = 4'b0000;
    @(negedge clk); // ACTIVE, grant ch0
    @(negedge clk); #1;
    checks++;
    if ({out_push, out_data} !== {1'b1, dv[0]}) begin
      errors++;
      $display("FAIL areset_setup push=%b data=%h expected 1/%h", out_push, out_data, dv[0]);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({state, out_push, out_data, fifo_rd, cfg_ae, cfg_af} !==
        {3'd0, 1'b0, 10'd0, 4'b0000, 3'd2, 3'd6}) begin
      errors++;
      $display("FAIL areset_immediate state=%0d push=%b data=%h rd=%b ae=%0d af=%0d",
               state, out_push, out_data, fifo_rd, cfg_ae, cfg_af);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); @(negedge clk); // INIT -> IDLE -> ACTIVE
    @(negedge clk); // grant ch0
    @(negedge clk); out_full = 1'b1; // push pending into full sink
    @(negedge clk); out_full = 1'b0; #1;
    checks++;
    if ({state, error_out} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL full_push_error state=%0d err=%b expected 4/1", state, error_out);
    end
  endtask

  initial begin
    dv[0] = 10'h155; dv[1] = 10'h2AA; dv[2] = 10'h0F0; dv[3] = 10'h30F;
    fifo_data = {dv[3], dv[2], dv[1], dv[0]};
    reset = 1'b1; init = 1'b0;
    umbral_ae_in = 3'd1; umbral_af_in = 3'd5;
    fifo_empty = 4'b1111; fifo_error = 4'b0000;
    out_almost_full = 1'b0; out_full = 1'b0;
    test_reset();
    test_init();
    test_round_robin();
    test_single_channel();
    test_almost_full();
    test_error();
    test_async_reset_and_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of source FIFOs (fixed at 4 for this revision).
REQ-002 SHALL have parameter WORD_SIZE, default 10, FIFO word width.
REQ-003 SHALL have parameter PTR_SIZE, default 3, threshold field width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port init  input  1  request to (re)load FIFO thresholds.
REQ-007 SHALL have port umbral_ae_in  input  PTR_SIZE  almost-empty threshold to program.
REQ-008 SHALL have port umbral_af_in  input  PTR_SIZE  almost-full threshold to program.
REQ-009 SHALL have port fifo_empty  input  NUM_CH  per-source empty flags.
REQ-010 SHALL have port fifo_error  input  NUM_CH  per-source error flags.
REQ-011 SHALL have port fifo_data  input  NUM_CH*WORD_SIZE  source data; channel i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-012 SHALL have port out_almost_full  input  1  sink FIFO almost-full flag.
REQ-013 SHALL have port out_full  input  1  sink FIFO full flag.
REQ-014 SHALL have port fifo_rd  output  NUM_CH  one-hot pop strobes to sources.
REQ-015 SHALL have port out_push  output  1  push strobe to sink.
REQ-016 SHALL have port out_data  output  WORD_SIZE  word pushed to sink.
REQ-017 SHALL have port cfg_ae, cfg_af  output  PTR_SIZE each  registered thresholds driven to all FIFOs.
REQ-018 SHALL have port cfg_load  output  1  high while thresholds are being loaded.
REQ-019 SHALL have port state  output  3  current FSM state encoding.
REQ-020 SHALL have ports idle_out, error_out  output  1 each  state indicators.

Function
REQ-021 SHALL implement FSM states RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-022 SHALL move RESET->INIT on the first clock edge after reset deasserts.
REQ-023 In INIT: cfg_load=1; cfg_ae/cfg_af latch umbral_ae_in/umbral_af_in every cycle; stay while init=1; init=0 -> IDLE.
REQ-024 In IDLE: no grants; idle_out=1; any fifo_empty bit 0 -> ACTIVE; init=1 -> INIT (init has priority).
REQ-025 In ACTIVE: all fifo_empty=1 and no pop in flight -> IDLE; init=1 -> INIT after the in-flight push completes.
REQ-026 Any fifo_error bit 1, or out_full=1 in a cycle with out_push=1, SHALL move any state except RESET to ERROR; ERROR is sticky until reset; error_out=1 in ERROR; no grants in ERROR.
REQ-027 Eligibility of channel i in cycle N: state ACTIVE, fifo_empty[i]=0, out_almost_full=0, and i not granted in cycle N-1 (masks stale empty flag).
REQ-028 SHALL grant at most one channel per cycle, round-robin starting from last_grant+1 modulo NUM_CH; last_grant updates only on a grant.
REQ-029 fifo_rd SHALL be combinational from registered state, one-hot or zero.
REQ-030 Grant in cycle N SHALL produce out_push=1 in cycle N+1, out_data = channel slice of fifo_data sampled in cycle N+1 (one-cycle read latency); grant index registered for this.
REQ-031 Throughput: up to one push per cycle across channels; at most one pop every two cycles per channel.
REQ-032 out_almost_full rising in cycle N SHALL stop grants in N; a push already in flight still completes in N+1.

Reset
REQ-033 On reset: state=RESET, fifo_rd=0, out_push=0, out_data=0, cfg_ae=2, cfg_af=6, cfg_load=0, last_grant=NUM_CH-1, error_out=0, idle_out=0.
REQ-034 Reset asserted mid-transfer SHALL clear all outputs immediately (asynchronously), discarding in-flight push.

Verification
REQ-035 Reset, init=1 for 3 cycles with umbral_ae_in=1, umbral_af_in=5, then init=0 -> cfg_load high 3 cycles, cfg_ae=1, cfg_af=5, state reaches IDLE (2).
REQ-036 All 4 sources non-empty continuously -> fifo_rd sequence 0001,0010,0100,1000,0001; out_push high every cycle after first; out_data matches granted channel.
REQ-037 Only channel 2 non-empty -> fifo_rd[2] pulses every other cycle; out_push alternates 1/0.
REQ-038 out_almost_full asserted mid-stream -> fifo_rd=0 same cycle, exactly one further out_push, resumes with next RR channel when deasserted.
REQ-039 fifo_error[1]=1 in ACTIVE -> state=ERROR (4), error_out=1, fifo_rd=0 until reset.
REQ-040 Reset asserted while out_push pending -> out_push=0 and state=RESET without waiting for a clock edge.
